// File: rtl/can_bus_link_model.sv
// Cycle-based CAN bus line: wired-AND of node transmitters with delay,
// fault injection, stuck-dominant detection and an edge counter.
module can_bus_link_model #(
  parameter int NUM_NODES    = 2,
  parameter int DELAY_CYCLES = 2,
  parameter int STUCK_LIMIT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic                 can_clk,
  input  logic                 can_rst,
  input  logic [NUM_NODES-1:0] can_tx,
  input  logic [NUM_NODES-1:0] node_en,
  output logic [NUM_NODES-1:0] can_rx,
  input  logic                 inj_req,
  input  logic [7:0]           inj_len,
  output logic                 inj_busy,
  output logic                 bus_level,
  output logic                 stuck_dom,
  output logic [CNT_W-1:0]     edge_cnt
);

  localparam int SW = $clog2(STUCK_LIMIT + 1);
  localparam logic [SW-1:0] STK_MAX = SW'(STUCK_LIMIT);

  typedef enum logic {
    IDLE,
    FORCE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] inj_cnt_q, inj_cnt_d;
  logic       raw;

  always_comb begin
    raw = &(can_tx | ~node_en) & (state_q != FORCE);
  end

  always_comb begin
    state_d   = state_q;
    inj_cnt_d = inj_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (inj_req && inj_len != 8'd0) begin
          state_d   = FORCE;
          inj_cnt_d = inj_len;
        end
      end
      FORCE: begin
        inj_cnt_d = inj_cnt_q - 8'd1;
        if (inj_cnt_q == 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge can_clk or posedge can_rst) begin
    if (can_rst) begin
      state_q   <= IDLE;
      inj_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      inj_cnt_q <= inj_cnt_d;
    end
  end

  assign inj_busy = (state_q == FORCE);

  // Zero delay makes the bus purely combinational.
  generate
    if (DELAY_CYCLES == 0) begin : g_nodly
      assign bus_level = raw;
    end else begin : g_dly
      logic [DELAY_CYCLES-1:0] dly_q, dly_d;

      always_comb begin
        dly_d[0] = raw;
        for (int i = 1; i < DELAY_CYCLES; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end

      always_ff @(posedge can_clk or posedge can_rst) begin
        if (can_rst) dly_q <= '1;
        else         dly_q <= dly_d;
      end

      assign bus_level = dly_q[DELAY_CYCLES-1];
    end
  endgenerate

  assign can_rx = ~node_en | {NUM_NODES{bus_level}};

  logic [SW-1:0]    stk_q, stk_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] edge_q, edge_d;

  always_comb begin
    stk_d  = stk_q;
    prev_d = bus_level;
    edge_d = edge_q;
    if (bus_level)            stk_d = '0;
    else if (stk_q != STK_MAX) stk_d = stk_q + 1'b1;
    if (prev_q && !bus_level && edge_q != '1) edge_d = edge_q + 1'b1;
  end

  always_ff @(posedge can_clk or posedge can_rst) begin
    if (can_rst) begin
      stk_q  <= '0;
      prev_q <= 1'b1;
      edge_q <= '0;
    end else begin
      stk_q  <= stk_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign stuck_dom = (stk_q == STK_MAX);
  assign edge_cnt  = edge_q;

endmodule

// File: tb/tb_can_bus_link_model.sv
// Bench for can_bus_link_model: directed scenarios plus random traffic
// against a cycle-history reference model.
module tb_can_bus_link_model;

  localparam int N  = 3;
  localparam int D  = 2;
  localparam int SL = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  tx, en, rx;
  logic          req;
  logic [7:0]    len;
  logic          busy, bus, stuck;
  logic [CW-1:0] ecnt;

  int total = 0;
  int passed = 0;
  int fails = 0;

  int rem;
  bit hist[$];
  bit m_bus, m_last;
  int run, edges;

  can_bus_link_model #(
    .NUM_NODES(N), .DELAY_CYCLES(D), .STUCK_LIMIT(SL), .CNT_W(CW)
  ) dut (
    .can_clk(clk), .can_rst(rst), .can_tx(tx), .node_en(en),
    .can_rx(rx), .inj_req(req), .inj_len(len), .inj_busy(busy),
    .bus_level(bus), .stuck_dom(stuck), .edge_cnt(ecnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rem = 0;
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back(1'b1);
    m_bus  = 1'b1;
    m_last = 1'b1;
    run    = 0;
    edges  = 0;
  endtask

  task automatic check_all();
    logic [N-1:0] erx;
    for (int i = 0; i < N; i++) erx[i] = en[i] ? m_bus : 1'b1;
    chk("bus_level", 32'(bus), 32'(m_bus));
    chk("can_rx", 32'(rx), 32'(erx));
    chk("inj_busy", 32'(busy), 32'(rem > 0));
    chk("stuck_dom", 32'(stuck), 32'(run >= SL));
    chk("edge_cnt", 32'(ecnt), 32'(edges));
  endtask

  task automatic step();
    bit all_rec, raw;
    all_rec = 1'b1;
    for (int i = 0; i < N; i++) if (en[i] && !tx[i]) all_rec = 1'b0;
    raw = all_rec && (rem == 0);
    @(posedge clk);
    if (m_last && !m_bus && edges < CMAX) edges++;
    m_last = m_bus;
    run = m_bus ? 0 : run + 1;
    hist.push_back(raw);
    while (hist.size() > D) void'(hist.pop_front());
    m_bus = hist[0];
    if (rem > 0) rem--;
    else if (req && len != 8'd0) rem = int'(len);
    #1;
    check_all();
    req = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tx  = '1;
    en  = '1;
    req = 1'b0;
    len = 8'd0;
    model_reset();
    #2 check_all();
    #10 rst = 1'b0;
    steps(2);

    // single node dominant burst
    tx = 3'b101; steps(5);
    tx = 3'b111; steps(6);

    // disconnected node is ignored until reconnected
    en = 3'b101; tx = 3'b101; steps(4);
    en = 3'b111; steps(4);
    tx = 3'b111; steps(4);

    // injection, request during burst, zero length
    len = 8'd4; req = 1'b1; step();
    step();
    len = 8'd9; req = 1'b1; step();
    steps(6);
    len = 8'd0; req = 1'b1; step();
    steps(4);

    // stuck-dominant detection and release
    tx = 3'b110; steps(20);
    tx = 3'b111; steps(4);

    // edge counter saturation
    for (int p = 0; p < 20; p++) begin
      tx = 3'b110; step();
      tx = 3'b111; steps(2);
    end
    steps(2);
    mid_reset();

    // reset during a long injection
    len = 8'd50; req = 1'b1; step();
    steps(5);
    mid_reset();
    steps(5);

    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) tx[i] = ($urandom_range(0, 3) != 0);
      en = N'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        req = 1'b1;
        len = 8'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 40) == 0) tx = 3'b000;
      step();
      if (k == 200) mid_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
